// File: rtl/traffic_defs.sv
// Shared signal-head encodings and scheduler state codes for the intersection
// controller, signal control and display logic.
package traffic_defs;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } light_t;

   // Code 7 is deliberately unused; the scheduler recovers from it to S_HG.
   typedef enum logic [2:0] {
      S_HG   = 3'd0,
      S_HY   = 3'd1,
      S_AR1  = 3'd2,
      S_CG   = 3'd3,
      S_CY   = 3'd4,
      S_AR2  = 3'd5,
      S_WALK = 3'd6
   } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase-dwell counter: synchronous clear on every phase change,
// asynchronous active-low reset.
module phase_timer #(
   parameter int CW = 8
) (
   input  logic          clock,
   input  logic          clear_n,
   input  logic          clr,
   output logic [CW-1:0] count
);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (count != {CW{1'b1}}) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/intersection_scheduler.sv
// Highway/country intersection phase scheduler with latched pedestrian
// request and emergency preemption; phase exposes the raw state register.
module intersection_scheduler
   import traffic_defs::*;
#(
   parameter int MIN_GREEN       = 4,
   parameter int MAX_CNTRY_GREEN = 6,
   parameter int WALK_TIME       = 5,
   parameter int CW              = 8
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       car_sensor,
   input  logic       ped_req,
   input  logic       emerg,
   input  logic [2:0] y2r_delay,
   input  logic [2:0] r2g_delay,
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   localparam logic [CW-1:0] MG_LIM   = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] MCG_LIM  = CW'(MAX_CNTRY_GREEN - 1);
   localparam logic [CW-1:0] WALK_LIM = CW'(WALK_TIME - 1);

   phase_t        state_q;
   phase_t        state_d;
   logic [CW-1:0] timer;
   logic [CW-1:0] y2r_lim;
   logic [CW-1:0] r2g_lim;
   logic          timer_clr;
   logic          enter_walk;
   logic          ped_pending_q;

   // Delay inputs are compared live every cycle, so retiming takes effect at once.
   assign y2r_lim    = {{(CW-3){1'b0}}, y2r_delay};
   assign r2g_lim    = {{(CW-3){1'b0}}, r2g_delay};
   assign timer_clr  = (state_d != state_q);
   assign enter_walk = (state_q == S_AR1) && (state_d == S_WALK);

   phase_timer #(.CW(CW)) u_timer (
      .clock   (clock),
      .clear_n (clear_n),
      .clr     (timer_clr),
      .count   (timer)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= S_HG;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HG: begin
            if ((timer >= MG_LIM) && (car_sensor || ped_pending_q) && !emerg)
               state_d = S_HY;
         end
         S_HY: begin
            if (timer >= y2r_lim) state_d = S_AR1;
         end
         S_AR1: begin
            if (timer >= r2g_lim) begin
               if (emerg)              state_d = S_HG;
               else if (ped_pending_q) state_d = S_WALK;
               else if (car_sensor)    state_d = S_CG;
               else                    state_d = S_HG;
            end
         end
         S_CG: begin
            if (emerg || !car_sensor || (timer >= MCG_LIM)) state_d = S_CY;
         end
         S_CY: begin
            if (timer >= y2r_lim) state_d = S_AR2;
         end
         S_AR2: begin
            if (timer >= r2g_lim) state_d = S_HG;
         end
         // WALK is all-red, so it may hand straight over to country green.
         S_WALK: begin
            if (timer >= WALK_LIM) state_d = car_sensor ? S_CG : S_HG;
         end
         default: state_d = S_HG;
      endcase
   end

   // A press landing in the WALK-entry cycle must survive, so set wins.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         ped_pending_q <= 1'b0;
         ped_ack       <= 1'b0;
      end else begin
         if (ped_req)         ped_pending_q <= 1'b1;
         else if (enter_walk) ped_pending_q <= 1'b0;
         ped_ack <= enter_walk;
      end
   end

   always_comb begin
      hwy   = RED;
      cntry = RED;
      walk  = 1'b0;
      case (state_q)
         S_HG:    hwy   = GREEN;
         S_HY:    hwy   = YELLOW;
         S_CG:    cntry = GREEN;
         S_CY:    cntry = YELLOW;
         S_WALK:  walk  = 1'b1;
         default: ;
      endcase
   end

   assign phase = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: phase sequences and dwell times
// checked cycle by cycle against hand-derived expectations.
module tb_intersection_scheduler;

   localparam logic [2:0] P_HG   = 3'd0;
   localparam logic [2:0] P_HY   = 3'd1;
   localparam logic [2:0] P_AR1  = 3'd2;
   localparam logic [2:0] P_CG   = 3'd3;
   localparam logic [2:0] P_CY   = 3'd4;
   localparam logic [2:0] P_AR2  = 3'd5;
   localparam logic [2:0] P_WALK = 3'd6;

   logic       clock      = 1'b0;
   logic       clear_n    = 1'b0;
   logic       car_sensor = 1'b0;
   logic       ped_req    = 1'b0;
   logic       emerg      = 1'b0;
   logic [2:0] y2r_delay  = 3'd2;
   logic [2:0] r2g_delay  = 3'd1;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   intersection_scheduler dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .car_sensor (car_sensor),
      .ped_req    (ped_req),
      .emerg      (emerg),
      .y2r_delay  (y2r_delay),
      .r2g_delay  (r2g_delay),
      .hwy        (hwy),
      .cntry      (cntry),
      .walk       (walk),
      .ped_ack    (ped_ack),
      .phase      (phase)
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_hwy(input logic [2:0] p);
      case (p)
         P_HG:    return 8'd2;
         P_HY:    return 8'd1;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic [7:0] exp_cntry(input logic [2:0] p);
      case (p)
         P_CG:    return 8'd2;
         P_CY:    return 8'd1;
         default: return 8'd0;
      endcase
   endfunction

   // Called on a falling edge; checks n consecutive cycles of phase p.
   // entry=1 means the first checked cycle is the first cycle of that phase.
   task automatic expect_run(input string tag, input logic [2:0] p, input int n,
                             input bit entry = 1'b1);
      for (int i = 0; i < n; i++) begin
         #1;
         check({tag, ".phase"}, 8'(phase), 8'(p));
         check({tag, ".hwy"},   8'(hwy),   exp_hwy(p));
         check({tag, ".cntry"}, 8'(cntry), exp_cntry(p));
         check({tag, ".walk"},  8'(walk),  8'(p == P_WALK));
         check({tag, ".ack"},   8'(ped_ack), 8'((p == P_WALK) && entry && (i == 0)));
         @(negedge clock);
      end
   endtask

   // Called on a falling edge; asserts reset mid-cycle, checks, releases on next fall.
   task automatic do_reset(input string tag);
      #2 clear_n = 1'b0;
      #1;
      check({tag, ".rst_phase"}, 8'(phase),   8'd0);
      check({tag, ".rst_hwy"},   8'(hwy),     8'd2);
      check({tag, ".rst_cntry"}, 8'(cntry),   8'd0);
      check({tag, ".rst_walk"},  8'(walk),    8'd0);
      check({tag, ".rst_ack"},   8'(ped_ack), 8'd0);
      @(negedge clock);
      clear_n = 1'b1;
   endtask

   task automatic ped_pulse_cycle1();
      fork
         begin
            @(negedge clock);
            ped_req = 1'b1;
            @(negedge clock);
            ped_req = 1'b0;
         end
      join_none
   endtask

   initial begin
      @(negedge clock);

      // 1: reset, idle highway green
      do_reset("t1");
      expect_run("t1_idle", P_HG, 20);

      // 2: car held from release
      car_sensor = 1'b1;
      do_reset("t2");
      expect_run("t2_hg",  P_HG,  4);
      expect_run("t2_hy",  P_HY,  3);
      expect_run("t2_ar1", P_AR1, 2);
      expect_run("t2_cg",  P_CG,  6);
      expect_run("t2_cy",  P_CY,  3);
      expect_run("t2_ar2", P_AR2, 2);
      expect_run("t2_hg2", P_HG,  4);
      expect_run("t2_hy2", P_HY,  1);

      // 3: single-cycle pedestrian press
      car_sensor = 1'b0;
      do_reset("t3");
      ped_pulse_cycle1();
      expect_run("t3_hg",   P_HG,   4);
      expect_run("t3_hy",   P_HY,   3);
      expect_run("t3_ar1",  P_AR1,  2);
      expect_run("t3_walk", P_WALK, 5);
      expect_run("t3_hg2",  P_HG,   6);

      // 4: emergency preempts country green
      car_sensor = 1'b1;
      do_reset("t4");
      expect_run("t4_hg",  P_HG,  4);
      expect_run("t4_hy",  P_HY,  3);
      expect_run("t4_ar1", P_AR1, 2);
      expect_run("t4_cg1", P_CG,  1);
      emerg = 1'b1;
      expect_run("t4_cg2", P_CG,  1, 1'b0);
      expect_run("t4_cy",  P_CY,  3);
      expect_run("t4_ar2", P_AR2, 2);
      expect_run("t4_hold", P_HG, 10);
      emerg = 1'b0;

      // 5a: zero yellow delay
      y2r_delay = 3'd0;
      do_reset("t5a");
      expect_run("t5a_hg",  P_HG,  4);
      expect_run("t5a_hy",  P_HY,  1);
      expect_run("t5a_ar1", P_AR1, 2);
      expect_run("t5a_cg",  P_CG,  1);

      // 5b: yellow delay lowered below elapsed count
      y2r_delay = 3'd7;
      do_reset("t5b");
      expect_run("t5b_hg", P_HG, 4);
      expect_run("t5b_hy", P_HY, 4);
      y2r_delay = 3'd1;
      expect_run("t5b_hy4", P_HY, 1, 1'b0);
      expect_run("t5b_ar1", P_AR1, 1);
      y2r_delay = 3'd2;

      // 6: reset during WALK with a new press pending
      car_sensor = 1'b0;
      do_reset("t6");
      ped_pulse_cycle1();
      expect_run("t6_hg",   P_HG,   4);
      expect_run("t6_hy",   P_HY,   3);
      expect_run("t6_ar1",  P_AR1,  2);
      expect_run("t6_walk", P_WALK, 1);
      ped_req = 1'b1;
      expect_run("t6_walk2", P_WALK, 1, 1'b0);
      ped_req = 1'b0;
      do_reset("t6_mid");
      expect_run("t6_idle", P_HG, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
